// File: rtl/ysyx_exu_wb_arb.sv
// Writeback arbiter: per-channel result FIFOs feeding up to NWB registered ROU write ports, round-robin.
// Optional macro YSYX_WB_BYPASS_EN lets an empty channel's incoming result compete in the same cycle.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

module ysyx_exu_wb_arb #(
  parameter int XLEN = `YSYX_XLEN,
  parameter int PLEN = `YSYX_PHY_LEN,
  parameter int RLEN = `YSYX_REG_LEN,
  parameter int DLEN = $clog2(`YSYX_ROB_SIZE) + 1,
  parameter int NCH  = 4,
  parameter int NWB  = 2,
  parameter int QD   = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NCH-1:0]                  in_valid,
  output logic [NCH-1:0]                  in_ready,
  input  logic [NCH-1:0][DLEN-1:0]        in_dest,
  input  logic [NCH-1:0][XLEN-1:0]        in_result,
  input  logic [NCH-1:0][XLEN-1:0]        in_pc,
  input  logic [NCH-1:0][PLEN-1:0]        in_prd,
  input  logic [NCH-1:0][RLEN-1:0]        in_rd,
  input  logic [NCH-1:0]                  in_trap,
  input  logic [NCH-1:0][XLEN-1:0]        in_cause,
  output logic [NWB-1:0]                  wb_valid,
  output logic [NWB-1:0][DLEN-1:0]        wb_dest,
  output logic [NWB-1:0][XLEN-1:0]        wb_result,
  output logic [NWB-1:0][XLEN-1:0]        wb_pc,
  output logic [NWB-1:0][PLEN-1:0]        wb_prd,
  output logic [NWB-1:0][RLEN-1:0]        wb_rd,
  output logic [NWB-1:0]                  wb_trap,
  output logic [NWB-1:0][XLEN-1:0]        wb_cause,
  output logic [NWB-1:0][$clog2(NCH)-1:0] wb_chan,
  output logic                            busy
);
  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(QD) + 1;
  localparam int EW = DLEN + 3 * XLEN + PLEN + RLEN + 1;

  logic [EW-1:0]          mem_r [NCH][QD];
  logic [PW-1:0]          wr_ptr_r [NCH];
  logic [PW-1:0]          rd_ptr_r [NCH];
  logic [CW-1:0]          rr_ptr_r;
  logic [NCH-1:0]         empty_s, full_s, avail_s, grant_s, push_s, pop_s;
  logic [EW-1:0]          entry_in_s [NCH];
  logic [EW-1:0]          head_s [NCH];
  int                     pos_s [NCH];
  int                     rank_s [NCH];
  int                     last_pos_s;
  int                     last_c_s;
  logic                   upd_s;
  logic [NWB-1:0]         port_vld_s;
  logic [NWB-1:0][CW-1:0] port_chan_s;
  logic [EW-1:0]          port_data_s [NWB];
  logic [CW-1:0]          rr_next_s;

  // Queue status, packed incoming entries and the entry each channel would hand out this cycle
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty_s[c]    = (wr_ptr_r[c] == rd_ptr_r[c]);
      full_s[c]     = (wr_ptr_r[c][PW-1] != rd_ptr_r[c][PW-1]) &&
                      (wr_ptr_r[c][PW-2:0] == rd_ptr_r[c][PW-2:0]);
      entry_in_s[c] = {in_dest[c], in_result[c], in_pc[c], in_prd[c], in_rd[c], in_trap[c], in_cause[c]};
      head_s[c]     = empty_s[c] ? entry_in_s[c] : mem_r[c][rd_ptr_r[c][PW-2:0]];
    end
  end

  assign in_ready = ~full_s & {NCH{~flush}};

`ifdef YSYX_WB_BYPASS_EN
  assign avail_s = ~empty_s | (in_valid & in_ready);
`else
  assign avail_s = ~empty_s;
`endif

  // A channel's rank is how many available channels precede it in the scan starting at rr_ptr
  always_comb begin
    grant_s     = '0;
    port_vld_s  = '0;
    port_chan_s = '0;
    last_pos_s  = -1;
    last_c_s    = 0;
    upd_s       = 1'b0;
    for (int k = 0; k < NWB; k++) port_data_s[k] = '0;
    for (int c = 0; c < NCH; c++) begin
      pos_s[c] = (c >= int'(rr_ptr_r)) ? (c - int'(rr_ptr_r)) : (c + NCH - int'(rr_ptr_r));
    end
    for (int c = 0; c < NCH; c++) begin
      rank_s[c] = 0;
      for (int d = 0; d < NCH; d++) begin
        rank_s[c] = rank_s[c] + ((avail_s[d] && (pos_s[d] < pos_s[c])) ? 1 : 0);
      end
      grant_s[c] = avail_s[c] && (rank_s[c] < NWB);
      for (int k = 0; k < NWB; k++) begin
        upd_s          = grant_s[c] && (rank_s[c] == k);
        port_vld_s[k]  = port_vld_s[k] | upd_s;
        port_chan_s[k] = port_chan_s[k] | ({CW{upd_s}} & CW'(c));
        port_data_s[k] = port_data_s[k] | ({EW{upd_s}} & head_s[c]);
      end
      upd_s      = grant_s[c] && (pos_s[c] > last_pos_s);
      last_pos_s = upd_s ? pos_s[c] : last_pos_s;
      last_c_s   = upd_s ? c : last_c_s;
    end
    rr_next_s = (last_pos_s < 0)      ? rr_ptr_r :
                (last_c_s == NCH - 1) ? {CW{1'b0}} : CW'(last_c_s + 1);
  end

  // A bypassed result (granted while its queue is empty) is never written into the queue
  assign push_s = in_valid & in_ready & ~(grant_s & empty_s);
  assign pop_s  = grant_s & ~empty_s;

  // Per-channel FIFO storage and pointers; flush empties every queue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        for (int q = 0; q < QD; q++) mem_r[c][q] <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push_s[c]) begin
          mem_r[c][wr_ptr_r[c][PW-2:0]] <= entry_in_s[c];
          wr_ptr_r[c]                   <= wr_ptr_r[c] + PW'(1'b1);
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PW'(1'b1);
        end
      end
    end
  end

  // Registered write ports and round-robin pointer; idle ports keep their last data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid  <= '0;
      wb_dest   <= '0;
      wb_result <= '0;
      wb_pc     <= '0;
      wb_prd    <= '0;
      wb_rd     <= '0;
      wb_trap   <= '0;
      wb_cause  <= '0;
      wb_chan   <= '0;
      rr_ptr_r  <= '0;
    end else if (flush) begin
      wb_valid <= '0;
      rr_ptr_r <= '0;
    end else begin
      wb_valid <= port_vld_s;
      rr_ptr_r <= rr_next_s;
      for (int k = 0; k < NWB; k++) begin
        if (port_vld_s[k]) begin
          {wb_dest[k], wb_result[k], wb_pc[k], wb_prd[k], wb_rd[k], wb_trap[k], wb_cause[k]} <= port_data_s[k];
          wb_chan[k] <= port_chan_s[k];
        end
      end
    end
  end

  assign busy = (|(~empty_s)) | (|wb_valid);

endmodule

// File: tb/tb_ysyx_exu_wb_arb.sv
// Scoreboard bench for ysyx_exu_wb_arb: queue-level reference model, directed scenarios plus random traffic.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

module tb_ysyx_exu_wb_arb;
  localparam int XLEN = `YSYX_XLEN;
  localparam int PLEN = `YSYX_PHY_LEN;
  localparam int RLEN = `YSYX_REG_LEN;
  localparam int DLEN = $clog2(`YSYX_ROB_SIZE) + 1;
  localparam int NCH  = 4;
  localparam int NWB  = 2;
  localparam int QD   = 2;
  localparam int CW   = $clog2(NCH);
`ifdef YSYX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [DLEN-1:0] dest;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc;
    logic [PLEN-1:0] prd;
    logic [RLEN-1:0] rd;
    logic            trap;
    logic [XLEN-1:0] cause;
  } ent_t;

  typedef struct packed {
    logic [NWB-1:0]         vld;
    logic [NWB-1:0][CW-1:0] ch;
    ent_t [NWB-1:0]         e;
    logic                   busy;
  } rec_t;

  logic                   clock, reset, flush;
  logic [NCH-1:0]         in_valid, in_ready, in_trap;
  logic [NCH-1:0][DLEN-1:0] in_dest;
  logic [NCH-1:0][XLEN-1:0] in_result, in_pc, in_cause;
  logic [NCH-1:0][PLEN-1:0] in_prd;
  logic [NCH-1:0][RLEN-1:0] in_rd;
  logic [NWB-1:0]         wb_valid, wb_trap;
  logic [NWB-1:0][DLEN-1:0] wb_dest;
  logic [NWB-1:0][XLEN-1:0] wb_result, wb_pc, wb_cause;
  logic [NWB-1:0][PLEN-1:0] wb_prd;
  logic [NWB-1:0][RLEN-1:0] wb_rd;
  logic [NWB-1:0][CW-1:0]   wb_chan;
  logic                   busy;

  ysyx_exu_wb_arb #(.XLEN(XLEN), .PLEN(PLEN), .RLEN(RLEN), .DLEN(DLEN),
                    .NCH(NCH), .NWB(NWB), .QD(QD)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_result(in_result),
    .in_pc(in_pc), .in_prd(in_prd), .in_rd(in_rd), .in_trap(in_trap), .in_cause(in_cause),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_pc(wb_pc),
    .wb_prd(wb_prd), .wb_rd(wb_rd), .wb_trap(wb_trap), .wb_cause(wb_cause),
    .wb_chan(wb_chan), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int             n_chk = 0;
  int             n_fail = 0;
  ent_t           mq [NCH][$];
  rec_t           sb [$];
  int             rr_m = 0;
  logic [NCH-1:0] offer_v = '0;
  ent_t           offer_e [NCH];
  logic           mon_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[$bits(ent_t)-1:0];
  endfunction

  // Reference: each queue is a list; scan from rr_m, grant the first NWB that have something to give.
  task automatic model_step(input logic [NCH-1:0] fire, input logic fl);
    rec_t           r;
    int             n, last, c;
    logic [NCH-1:0] byp;
    r = '0;
    byp = '0;
    if (fl) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      n = 0;
      last = -1;
      for (int j = 0; j < NCH; j++) begin
        c = (rr_m + j) % NCH;
        if (n < NWB && (mq[c].size() > 0 || (BYP && fire[c]))) begin
          for (int k = 0; k < NWB; k++) begin
            if (k == n) begin
              r.vld[k] = 1'b1;
              r.ch[k]  = CW'(c);
              if (mq[c].size() > 0) r.e[k] = mq[c].pop_front();
              else begin
                r.e[k] = offer_e[c];
                byp[c] = 1'b1;
              end
            end
          end
          n++;
          last = c;
        end
      end
      for (int i = 0; i < NCH; i++) if (fire[i] && !byp[i]) mq[i].push_back(offer_e[i]);
      if (n > 0) rr_m = (last + 1) % NCH;
    end
    r.busy = (r.vld != '0);
    for (int i = 0; i < NCH; i++) if (mq[i].size() > 0) r.busy = 1'b1;
    sb.push_back(r);
  endtask

  task automatic drive(input logic fl);
    for (int c = 0; c < NCH; c++) begin
      in_valid[c]  = offer_v[c];
      in_dest[c]   = offer_e[c].dest;
      in_result[c] = offer_e[c].result;
      in_pc[c]     = offer_e[c].pc;
      in_prd[c]    = offer_e[c].prd;
      in_rd[c]     = offer_e[c].rd;
      in_trap[c]   = offer_e[c].trap;
      in_cause[c]  = offer_e[c].cause;
    end
    flush = fl;
  endtask

  // One cycle: new offers on idle channels in newm, pending offers held until accepted, flush drops them.
  task automatic step(input logic [NCH-1:0] newm, input logic fl);
    logic [NCH-1:0] rdy, fire;
    @(negedge clock);
    for (int c = 0; c < NCH; c++) begin
      if (!offer_v[c] && newm[c]) begin
        offer_v[c] = 1'b1;
        offer_e[c] = rand_ent();
      end
    end
    drive(fl);
    for (int c = 0; c < NCH; c++) rdy[c] = (mq[c].size() < QD) && !fl;
    #1;
    check("in_ready", in_ready, rdy);
    fire = offer_v & rdy;
    model_step(fire, fl);
    mon_en = 1'b1;
    for (int c = 0; c < NCH; c++) if (fire[c] || fl) offer_v[c] = 1'b0;
  endtask

  task automatic force_offer(input int c, input ent_t e);
    offer_v[c] = 1'b1;
    offer_e[c] = e;
  endtask

  // Monitor: compare every cycle; idle ports must hold the last data they carried
  initial begin
    rec_t r;
    ent_t hold_e [NWB];
    logic [CW-1:0] hold_ch [NWB];
    for (int k = 0; k < NWB; k++) begin
      hold_e[k]  = '0;
      hold_ch[k] = '0;
    end
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got no expected record at %0t", $time);
        end else begin
          r = sb.pop_front();
          check("wb_valid", wb_valid, r.vld);
          check("busy", busy, r.busy);
          for (int k = 0; k < NWB; k++) begin
            if (r.vld[k]) begin
              hold_e[k]  = r.e[k];
              hold_ch[k] = r.ch[k];
            end
            check("wb_data", {wb_dest[k], wb_result[k], wb_pc[k], wb_prd[k], wb_rd[k], wb_trap[k], wb_cause[k]},
                  hold_e[k]);
            check("wb_chan", wb_chan[k], hold_ch[k]);
          end
        end
      end
    end
  end

  initial begin
    ent_t e;
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) offer_e[c] = '0;
    drive(1'b0);
    repeat (3) @(negedge clock);
    check("reset_wb_valid", wb_valid, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 4'b1111);
    check("reset_wb_dest", wb_dest, '0);
    reset = 1'b1;

    // first single push: ch2, dest 5
    e = rand_ent();
    e.dest = 5'd5;
    force_offer(2, e);
    repeat (4) step(4'b0000, 1'b0);

    // fairness: all channels continuously valid
    repeat (16) step(4'b1111, 1'b0);
    repeat (6) step(4'b0000, 1'b0);

    // full: ch0/ch3 kept busy while ch1 offers three results
    for (int i = 0; i < 12; i++) step((i < 3) ? 4'b1011 : 4'b1001, 1'b0);
    repeat (6) step(4'b0000, 1'b0);

    // flush alongside a new ch0 push
    repeat (4) step(4'b1111, 1'b0);
    e = rand_ent();
    force_offer(0, e);
    step(4'b0000, 1'b1);
    repeat (3) step(4'b0000, 1'b0);

    // trap passthrough on ch1
    e = rand_ent();
    e.trap  = 1'b1;
    e.cause = 32'h2;
    force_offer(1, e);
    repeat (4) step(4'b0000, 1'b0);

    // random traffic with occasional flushes
    repeat (400) step(NCH'($urandom), ($urandom_range(29, 0) == 0));
    repeat (8) step(4'b0000, 1'b0);

    @(posedge clock);
    #2;
    mon_en = 1'b0;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d records expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
